// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if
//   Groups the alarm sequencer's control inputs and status outputs.
//   master : the driving side (clock top level / bench): drives tick, buzz,
//            alarm_on, snooze, dismiss; observes ring, snoozing, snooze_cnt,
//            timed_out.
//   slave  : the sequencer itself (directions reversed).
interface alarm_sequencer_if;
  logic       tick;
  logic       buzz;
  logic       alarm_on;
  logic       snooze;
  logic       dismiss;
  logic       ring;
  logic       snoozing;
  logic [3:0] snooze_cnt;
  logic       timed_out;

  modport master (
    output tick, buzz, alarm_on, snooze, dismiss,
    input  ring, snoozing, snooze_cnt, timed_out
  );

  modport slave (
    input  tick, buzz, alarm_on, snooze, dismiss,
    output ring, snoozing, snooze_cnt, timed_out
  );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//   Turns the alarm comparator's level 'buzz' into a timed ring with snooze,
//   dismiss and auto-timeout. All timing counts 1 Hz 'tick' strobes.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : alarm_sequencer_if.slave
//              in : tick, buzz, alarm_on, snooze, dismiss
//              out: ring, snoozing, snooze_cnt[3:0], timed_out (all registered)
//   Optional build macro: BEEP_PATTERN_EN -- ring beeps 1 s on / 1 s off
//   (starting on) instead of staying steady for the whole ring.
module alarm_sequencer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input logic             clk,
  input logic             rst_n,
  alarm_sequencer_if.slave bus
);
  localparam int LIM = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW  = $clog2(LIM + 1);
  localparam logic [CW-1:0] RING_LAST   = CW'(RING_SECS - 1);
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SECS - 1);
  localparam logic [3:0]    SNZ_MAX     = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic          buzz_q, snz_q, dis_q;
  logic          ring_r, snoozing_r, timed_out_r;
  logic [3:0]    snooze_cnt_r;
`ifdef BEEP_PATTERN_EN
  logic          phase;
`endif

  logic buzz_rise, snz_rise, dis_rise;
  assign buzz_rise = bus.buzz    & ~buzz_q;
  assign snz_rise  = bus.snooze  & ~snz_q;
  assign dis_rise  = bus.dismiss & ~dis_q;

  assign bus.ring       = ring_r;
  assign bus.snoozing   = snoozing_r;
  assign bus.snooze_cnt = snooze_cnt_r;
  assign bus.timed_out  = timed_out_r;

  // Outputs are updated on the same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      counter      <= '0;
      // Edge registers reset high: a level already high at release is not an edge.
      buzz_q       <= 1'b1;
      snz_q        <= 1'b1;
      dis_q        <= 1'b1;
      ring_r       <= 1'b0;
      snoozing_r   <= 1'b0;
      snooze_cnt_r <= 4'd0;
      timed_out_r  <= 1'b0;
`ifdef BEEP_PATTERN_EN
      phase        <= 1'b0;
`endif
    end else begin
      buzz_q      <= bus.buzz;
      snz_q       <= bus.snooze;
      dis_q       <= bus.dismiss;
      timed_out_r <= 1'b0;
      if (!bus.alarm_on) begin
        // Disable wins over everything else.
        state        <= IDLE;
        counter      <= '0;
        ring_r       <= 1'b0;
        snoozing_r   <= 1'b0;
        snooze_cnt_r <= 4'd0;
      end else begin
        unique case (state)
          IDLE: begin
            if (buzz_rise) begin
              state   <= RING;
              counter <= '0;
              ring_r  <= 1'b1;
`ifdef BEEP_PATTERN_EN
              phase   <= 1'b0;
`endif
            end
          end
          RING: begin
            if (dis_rise) begin
              state        <= IDLE;
              counter      <= '0;
              ring_r       <= 1'b0;
              snooze_cnt_r <= 4'd0;
            end else if (snz_rise && snooze_cnt_r < SNZ_MAX) begin
              state        <= SNOOZE;
              counter      <= '0;
              ring_r       <= 1'b0;
              snoozing_r   <= 1'b1;
              snooze_cnt_r <= snooze_cnt_r + 4'd1;
            end else if (bus.tick && counter == RING_LAST) begin
              state        <= IDLE;
              counter      <= '0;
              ring_r       <= 1'b0;
              snooze_cnt_r <= 4'd0;
              timed_out_r  <= 1'b1;
            end else if (bus.tick) begin
              counter <= counter + CW'(1);
`ifdef BEEP_PATTERN_EN
              // ring = ~phase_next, and phase_next = ~phase.
              phase   <= ~phase;
              ring_r  <= phase;
`endif
            end
          end
          SNOOZE: begin
            if (dis_rise) begin
              state        <= IDLE;
              counter      <= '0;
              snoozing_r   <= 1'b0;
              snooze_cnt_r <= 4'd0;
            end else if (bus.tick && counter == SNOOZE_LAST) begin
              state      <= RING;
              counter    <= '0;
              snoozing_r <= 1'b0;
              ring_r     <= 1'b1;
`ifdef BEEP_PATTERN_EN
              phase      <= 1'b0;
`endif
            end else if (bus.tick) begin
              counter <= counter + CW'(1);
            end
          end
          default: begin
            state        <= IDLE;
            counter      <= '0;
            ring_r       <= 1'b0;
            snoozing_r   <= 1'b0;
            snooze_cnt_r <= 4'd0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alarm_sequencer.sv
module tb_alarm_sequencer;
  typedef struct packed {
    logic       ring;
    logic       snoozing;
    logic [3:0] cnt;
    logic       timed_out;
  } obs_t;

`ifdef BEEP_PATTERN_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];
  obs_t got, want;

  alarm_sequencer_if bus();

  alarm_sequencer #(.RING_SECS(4), .SNOOZE_SECS(3), .MAX_SNOOZE(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t cur();
    return {bus.ring, bus.snoozing, bus.snooze_cnt, bus.timed_out};
  endfunction

  function automatic obs_t mk(logic r, logic s, logic [3:0] c, logic t);
    return {r, s, c, t};
  endfunction

  // One clock; inputs change 1 time unit after the edge, outputs sampled there.
  task automatic cyc(input logic t);
    bus.tick = t;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
  endtask

  task automatic tick_period();
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
  endtask

  task automatic test_reset();
    bus.tick = 0; bus.buzz = 1; bus.alarm_on = 1; bus.snooze = 0; bus.dismiss = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(mk(0, 0, 0, 0));
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_state got=%b want=%b", got, want); end
    rst_n = 1;
    sb.push_back(mk(0, 0, 0, 0));
    repeat (3) cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_buzz_held got=%b want=%b", got, want); end
    bus.buzz = 0; cyc(1'b0);
  endtask

  task automatic test_timeout();
    bus.buzz = 1;
    sb.push_back(mk(1, 0, 0, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL timeout_start got=%b want=%b", got, want); end
    for (int k = 1; k <= 3; k++) begin
      sb.push_back(mk(BEEP ? (k % 2 == 0) : 1'b1, 0, 0, 0));
      tick_period();
      got = cur(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL timeout_tick%0d got=%b want=%b", k, got, want); end
    end
    sb.push_back(mk(0, 0, 0, 1));
    tick_period();
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL timeout_end got=%b want=%b", got, want); end
    sb.push_back(mk(0, 0, 0, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL timeout_pulse_width got=%b want=%b", got, want); end
    bus.buzz = 0; cyc(1'b0);
  endtask

  task automatic test_snooze();
    bus.buzz = 1; cyc(1'b0);
    bus.snooze = 1;
    sb.push_back(mk(0, 1, 1, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL snooze_enter got=%b want=%b", got, want); end
    bus.snooze = 0;
    sb.push_back(mk(0, 1, 1, 0));
    tick_period(); tick_period();
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL snooze_hold got=%b want=%b", got, want); end
    sb.push_back(mk(1, 0, 1, 0));
    tick_period();
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL snooze_rering got=%b want=%b", got, want); end
    bus.snooze = 1;
    sb.push_back(mk(0, 1, 2, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL snooze_second got=%b want=%b", got, want); end
    bus.snooze = 0;
    repeat (3) tick_period();
    bus.snooze = 1;
    sb.push_back(mk(1, 0, 2, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL snooze_max_ignored got=%b want=%b", got, want); end
    bus.snooze = 0; cyc(1'b0);
    bus.dismiss = 1;
    sb.push_back(mk(0, 0, 0, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL snooze_dismiss got=%b want=%b", got, want); end
    bus.dismiss = 0; bus.buzz = 0; cyc(1'b0);
  endtask

  task automatic test_simultaneous();
    bus.buzz = 1; cyc(1'b0);
    bus.snooze = 1; cyc(1'b0);
    bus.snooze = 0;
    repeat (3) tick_period();
    bus.snooze = 1; bus.dismiss = 1;
    sb.push_back(mk(0, 0, 0, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL snooze_and_dismiss got=%b want=%b", got, want); end
    bus.snooze = 0; bus.dismiss = 0; bus.buzz = 0; cyc(1'b0);
    bus.buzz = 1; cyc(1'b0);
    bus.snooze = 1; cyc(1'b0);
    bus.snooze = 0; bus.buzz = 0; cyc(1'b0);
    bus.buzz = 1;
    sb.push_back(mk(0, 1, 1, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL buzz_in_snooze got=%b want=%b", got, want); end
  endtask

  task automatic test_alarm_off();
    bus.alarm_on = 0;
    sb.push_back(mk(0, 0, 0, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL alarm_off_snooze got=%b want=%b", got, want); end
    bus.buzz = 0; cyc(1'b0);
    bus.buzz = 1;
    sb.push_back(mk(0, 0, 0, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL alarm_off_no_trigger got=%b want=%b", got, want); end
    bus.buzz = 0; bus.alarm_on = 1; cyc(1'b0);
  endtask

  task automatic test_async_reset();
    bus.buzz = 1;
    sb.push_back(mk(1, 0, 0, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL async_pre_ring got=%b want=%b", got, want); end
    #2 rst_n = 0;
    #1;
    sb.push_back(mk(0, 0, 0, 0));
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL async_reset_immediate got=%b want=%b", got, want); end
    #2 rst_n = 1;
    sb.push_back(mk(0, 0, 0, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL async_no_retrigger got=%b want=%b", got, want); end
    bus.buzz = 0; cyc(1'b0);
    bus.buzz = 1;
    sb.push_back(mk(1, 0, 0, 0));
    cyc(1'b0);
    got = cur(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL async_back_to_back got=%b want=%b", got, want); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_snooze();
    test_simultaneous();
    test_alarm_off();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
